// File: rtl/r_alu_encoder_pkg.sv
// Shared op codes, LEGv8 opcode fields and FSM state type for the ALU instruction encoder.
package r_alu_encoder_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_ADDS  = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_SUBS  = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_ANDS  = 4'd5;
    localparam logic [3:0] OP_ORR   = 4'd6;
    localparam logic [3:0] OP_EOR   = 4'd7;
    localparam logic [3:0] OP_ADDI  = 4'd8;
    localparam logic [3:0] OP_ADDIS = 4'd9;
    localparam logic [3:0] OP_SUBI  = 4'd10;
    localparam logic [3:0] OP_SUBIS = 4'd11;
    localparam logic [3:0] OP_ANDI  = 4'd12;
    localparam logic [3:0] OP_ORRI  = 4'd13;
    localparam logic [3:0] OP_EORI  = 4'd14;
    localparam logic [3:0] OP_ILL   = 4'd15;

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_ADDS = 11'b10101011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_SUBS = 11'b11101011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ANDS = 11'b11101010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_EOR  = 11'b11001010000;

    localparam logic [9:0] OPC_ADDI  = 10'b1001000100;
    localparam logic [9:0] OPC_ADDIS = 10'b1011000100;
    localparam logic [9:0] OPC_SUBI  = 10'b1101000100;
    localparam logic [9:0] OPC_SUBIS = 10'b1111000100;
    localparam logic [9:0] OPC_ANDI  = 10'b1001001000;
    localparam logic [9:0] OPC_ORRI  = 10'b1011001000;
    localparam logic [9:0] OPC_EORI  = 10'b1101001000;

    typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

    function automatic logic is_itype(input logic [3:0] op);
        return (op >= OP_ADDI) && (op <= OP_EORI);
    endfunction

endpackage

// File: rtl/r_alu_encoder_encode.sv
// Combinational field-to-word encoder for LEGv8 R-type and I-type ALU instructions.
module legv8_alu_encode
    import r_alu_encoder_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rn,
    input  logic [4:0]  rm,
    input  logic [5:0]  shamt,
    input  logic [11:0] imm12,
    output logic [31:0] word,
    output logic        legal
);
    logic [10:0] opc_r;
    logic [9:0]  opc_i;

    always_comb begin
        opc_r = '0;
        opc_i = '0;
        legal = 1'b1;
        case (op)
            OP_ADD:   opc_r = OPC_ADD;
            OP_ADDS:  opc_r = OPC_ADDS;
            OP_SUB:   opc_r = OPC_SUB;
            OP_SUBS:  opc_r = OPC_SUBS;
            OP_AND:   opc_r = OPC_AND;
            OP_ANDS:  opc_r = OPC_ANDS;
            OP_ORR:   opc_r = OPC_ORR;
            OP_EOR:   opc_r = OPC_EOR;
            OP_ADDI:  opc_i = OPC_ADDI;
            OP_ADDIS: opc_i = OPC_ADDIS;
            OP_SUBI:  opc_i = OPC_SUBI;
            OP_SUBIS: opc_i = OPC_SUBIS;
            OP_ANDI:  opc_i = OPC_ANDI;
            OP_ORRI:  opc_i = OPC_ORRI;
            OP_EORI:  opc_i = OPC_EORI;
            default:  legal = 1'b0;
        endcase
        // Unused format fields never reach the word.
        if (!legal)
            word = '0;
        else if (is_itype(op))
            word = {opc_i, imm12, rn, rd};
        else
            word = {opc_r, rm, shamt, rn, rd};
    end
endmodule

// File: rtl/r_alu_encoder.sv
// Accepts ALU op requests, encodes them and writes them sequentially into instruction memory.
module r_alu_encoder
    import r_alu_encoder_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR   = 64'd0,
    parameter int          DEPTH_WORDS = 64,
    parameter int          CNT_W       = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [4:0]       rd,
    input  logic [4:0]       rn,
    input  logic [4:0]       rm,
    input  logic [5:0]       shamt,
    input  logic [11:0]      imm12,
    output logic             mem_we,
    output logic [63:0]      mem_addr,
    output logic [31:0]      mem_data,
    input  logic             mem_ack,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic             err
);
    state_t      state;
    logic [31:0] word;
    logic        legal;

    legv8_alu_encode u_enc (
        .op    (op),
        .rd    (rd),
        .rn    (rn),
        .rm    (rm),
        .shamt (shamt),
        .imm12 (imm12),
        .word  (word),
        .legal (legal)
    );

    // start takes priority over a same-cycle request, so it blocks the handshake.
    assign in_ready = reset && (state == IDLE) && !start;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            mem_we   <= 1'b0;
            mem_addr <= BASE_ADDR;
            mem_data <= '0;
            count    <= '0;
            full     <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr <= BASE_ADDR;
                        count    <= '0;
                        full     <= 1'b0;
                        err      <= 1'b0;
                    end else if (in_valid) begin
                        if (legal) begin
                            mem_data <= word;
                            mem_we   <= 1'b1;
                            state    <= WRITE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_we   <= 1'b0;
                        mem_addr <= mem_addr + 64'd4;
                        count    <= count + 1'b1;
                        if (count == CNT_W'(DEPTH_WORDS - 1)) begin
                            full  <= 1'b1;
                            state <= FULL;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                FULL: begin
                    if (start) begin
                        mem_addr <= BASE_ADDR;
                        count    <= '0;
                        full     <= 1'b0;
                        err      <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_r_alu_encoder.sv
// Directed plus randomized check of r_alu_encoder against a transaction-level model.
module tb_r_alu_encoder;
    localparam int          DEPTH = 4;
    localparam int          CW    = 7;
    localparam logic [63:0] BASE  = 64'd0;

    logic          clock = 1'b0;
    logic          reset, start, in_valid, mem_ack;
    logic          in_ready, mem_we, full, err;
    logic [3:0]    op;
    logic [4:0]    rd, rn, rm;
    logic [5:0]    shamt;
    logic [11:0]   imm12;
    logic [63:0]   mem_addr;
    logic [31:0]   mem_data;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    // model: outstanding write, full flag, sticky err, next address, words written, last word
    bit          m_wr, m_full, m_err;
    logic [63:0] m_addr;
    int          m_cnt;
    logic [31:0] m_data;

    r_alu_encoder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rd(rd), .rn(rn), .rm(rm), .shamt(shamt), .imm12(imm12),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
        .full(full), .count(count), .err(err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Opcode table from the LEGv8 ALU instruction list; word built by place-value arithmetic.
    function automatic logic [31:0] ref_enc(input int o, input int d, input int n, input int m,
                                            input int s, input int i);
        longint w;
        int r_tab[8] = '{'b10001011000, 'b10101011000, 'b11001011000, 'b11101011000,
                         'b10001010000, 'b11101010000, 'b10101010000, 'b11001010000};
        int i_tab[7] = '{'b1001000100, 'b1011000100, 'b1101000100, 'b1111000100,
                         'b1001001000, 'b1011001000, 'b1101001000};
        if (o < 8)
            w = longint'(r_tab[o]) * (1 << 21) + m * (1 << 16) + s * (1 << 10) + n * 32 + d;
        else
            w = longint'(i_tab[o - 8]) * (1 << 22) + i * (1 << 10) + n * 32 + d;
        return w[31:0];
    endfunction

    task automatic cyc(input bit v, input int o, input int d, input int n, input int m,
                       input int s, input int i, input bit ack, input bit st, input bit rst);
        @(negedge clock);
        in_valid = v; op = 4'(o); rd = 5'(d); rn = 5'(n); rm = 5'(m);
        shamt = 6'(s); imm12 = 12'(i); mem_ack = ack; start = st; reset = rst;
        #1;
        chk("in_ready", in_ready, rst && !m_wr && !m_full && !st);
        @(posedge clock);
        if (!rst) begin
            m_wr = 0; m_full = 0; m_err = 0; m_addr = BASE; m_cnt = 0; m_data = 0;
        end else if (m_wr) begin
            if (ack) begin
                m_wr = 0; m_addr += 4; m_cnt++;
                if (m_cnt == DEPTH) m_full = 1;
            end
        end else if (st) begin
            m_full = 0; m_err = 0; m_addr = BASE; m_cnt = 0;
        end else if (!m_full && v) begin
            if (o == 15) m_err = 1;
            else begin m_wr = 1; m_data = ref_enc(o, d, n, m, s, i); end
        end
        #1;
        chk("mem_we", mem_we, m_wr);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_data", mem_data, m_data);
        chk("count", count, m_cnt);
        chk("full", full, m_full);
        chk("err", err, m_err);
    endtask

    initial begin
        reset = 0; start = 0; in_valid = 0; mem_ack = 0;
        op = 0; rd = 0; rn = 0; rm = 0; shamt = 0; imm12 = 0;
        m_wr = 0; m_full = 0; m_err = 0; m_addr = BASE; m_cnt = 0; m_data = 0;

        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, BASE);

        // ADD X3,X1,X2 then ack
        cyc(1, 0, 3, 1, 2, 0, 0, 0, 0, 1);
        chk("add_word", mem_data, 32'h8B020023);
        chk("add_addr", mem_addr, 64'd0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        chk("add_cnt", count, 1);
        chk("add_next", mem_addr, 64'd4);

        // ADDI X5,X4,#10 with R-type noise, stalled five cycles with start pulses
        cyc(1, 8, 5, 4, 31, 63, 10, 0, 0, 1);
        chk("addi_word", mem_data, 32'h91002885);
        for (int k = 0; k < 5; k++) cyc(1, 1, 7, 7, 7, 7, 7, 0, k[0], 1);
        chk("stall_word", mem_data, 32'h91002885);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);

        // illegal op, following legal op, start clears err
        cyc(1, 15, 1, 1, 1, 1, 1, 0, 0, 1);
        chk("ill_err", err, 1);
        cyc(1, 7, 9, 8, 6, 2, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        chk("ill_cnt", count, 3);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("start_err", err, 0);

        // fill to capacity
        for (int k = 0; k < DEPTH; k++) begin
            cyc(1, k + 10, k, k + 1, 0, 0, k * 5, 0, 0, 1);
            if (k == DEPTH - 1) chk("last_addr", mem_addr, 64'd12);
            cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        end
        chk("full_set", full, 1);
        cyc(1, 0, 1, 1, 1, 0, 0, 1, 0, 1);
        chk("full_we", mem_we, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("restart_addr", mem_addr, BASE);
        chk("restart_full", full, 0);

        // reset mid-write
        cyc(1, 3, 2, 2, 2, 2, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rstw_we", mem_we, 0);

        for (int k = 0; k < 3000; k++)
            cyc($urandom_range(1, 0) == 1, $urandom_range(15, 0), $urandom_range(31, 0),
                $urandom_range(31, 0), $urandom_range(31, 0), $urandom_range(63, 0),
                $urandom_range(4095, 0), $urandom_range(1, 0) == 1,
                $urandom_range(15, 0) == 0, $urandom_range(63, 0) != 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
